// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode,
// execute, memory access and writeback for lw/sw/R-type/beq/addi/j.
// Optional macro MIPS_MC_IMM_LOGIC_EN adds andi/ori via state IMMLEX and
// the imm_zext output port.
//
// state  | meaning
// FETCH  | read instruction at PC into IR, PC <= PC + 4
// DECODE | read registers, precompute branch target into ALUOut
// MEMADR | compute lw/sw effective address
// MEMRD  | read data memory at ALUOut
// MEMWB  | write MDR into rt
// MEMWR  | write regB to data memory at ALUOut
// EXEC   | R-type ALU operation selected by funct
// ALUWB  | write ALUOut into rd
// BRANCH | compare regA/regB, load PC from ALUOut when equal
// ADDIEX | regA + sign-extended immediate
// ADDIWB | write ALUOut into rt
// JUMP   | load PC with jump target
// IMMLEX | regA AND/OR zero-extended immediate (optional)
module mips_mc_control #(
   parameter int ALU_W = 4,
   parameter int ST_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic [ALU_W-1:0] alu_control,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal_op,
   output logic [ST_W-1:0]  estado
`ifdef MIPS_MC_IMM_LOGIC_EN
   ,
   output logic             imm_zext
`endif
);

   typedef enum logic [ST_W-1:0] {
      FETCH  = ST_W'(0),
      DECODE = ST_W'(1),
      MEMADR = ST_W'(2),
      MEMRD  = ST_W'(3),
      MEMWB  = ST_W'(4),
      MEMWR  = ST_W'(5),
      EXEC   = ST_W'(6),
      ALUWB  = ST_W'(7),
      BRANCH = ST_W'(8),
      ADDIEX = ST_W'(9),
      ADDIWB = ST_W'(10),
      JUMP   = ST_W'(11),
      IMMLEX = ST_W'(12)
   } state_e;

   localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'b0000);
   localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'b0001);
   localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'b0010);
   localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'b0110);
   localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4'b0111);
   localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(4'b1100);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   state_e           state_q, state_d, state_eff;
   logic             illegal_q, illegal_d;
   logic             funct_ok;
   logic [ALU_W-1:0] funct_alu;
   logic             pc_write, branch;
   logic             ir_write_c, mem_write_c, reg_write_c;
   logic             imm_zext_c;

   // R-type funct decode: legality (used in DECODE) and ALU op (used in EXEC)
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         6'b100111: funct_alu = ALU_NOR;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state and Moore outputs; reset presents FETCH outputs with enables off
   always_comb begin
      state_eff   = rst_n ? state_q : FETCH;
      state_d     = FETCH;
      illegal_d   = illegal_q;
      alu_control = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      pc_write    = 1'b0;
      branch      = 1'b0;
      i_or_d      = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      imm_zext_c  = 1'b0;
      case (state_eff)
         FETCH: begin
            ir_write_c = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b01;
            state_d    = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               OP_RTYPE: begin
                  if (funct_ok) state_d = EXEC;
                  else          illegal_d = 1'b1;
               end
`ifdef MIPS_MC_IMM_LOGIC_EN
               OP_ANDI, OP_ORI: state_d = IMMLEX;
`endif
               default: illegal_d = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            i_or_d  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            reg_write_c = 1'b1;
            mem_to_reg  = 1'b1;
         end
         MEMWR: begin
            i_or_d      = 1'b1;
            mem_write_c = 1'b1;
         end
         EXEC: begin
            alu_src_a   = 1'b1;
            alu_control = funct_alu;
            state_d     = ALUWB;
         end
         ALUWB: begin
            reg_write_c = 1'b1;
            reg_dst     = 1'b1;
         end
         BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            branch      = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: reg_write_c = 1'b1;
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
`ifdef MIPS_MC_IMM_LOGIC_EN
         IMMLEX: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            imm_zext_c  = 1'b1;
            state_d     = ADDIWB;
         end
`endif
         default: state_d = FETCH;
      endcase
      pc_en      = rst_n & (pc_write | (branch & zero));
      ir_write   = rst_n & ir_write_c;
      mem_write  = rst_n & mem_write_c;
      reg_write  = rst_n & reg_write_c;
   end

   // State and sticky illegal flag, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal_op = illegal_q;
   assign estado     = state_q;
`ifdef MIPS_MC_IMM_LOGIC_EN
   assign imm_zext   = imm_zext_c;
`else
   logic unused_imm;
   assign unused_imm = imm_zext_c;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle expectation table plus
// hand-written reset sequences.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, funct;
   logic       zero;
   logic [3:0] alu_control;
   logic       alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic       pc_en, i_or_d, mem_write, ir_write, reg_write;
   logic       reg_dst, mem_to_reg, illegal_op;
   logic [3:0] estado;
`ifdef MIPS_MC_IMM_LOGIC_EN
   logic       imm_zext;
`endif

   mips_mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_src(pc_src), .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .estado(estado)
`ifdef MIPS_MC_IMM_LOGIC_EN
      , .imm_zext(imm_zext)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic [3:0] st;
      logic [3:0] alu;
      logic [3:0] en;   // {pc_en, ir_write, mem_write, reg_write}
      logic [8:0] mux;  // {src_a, src_b[1:0], pc_src[1:0], i_or_d, reg_dst, mem_to_reg}
      logic       imm;
      logic       ill;
   } vec_t;

   // expected mux fields per state, hand-derived
   localparam logic [8:0] M_F   = 9'b0_01_00_0_0_0;
   localparam logic [8:0] M_D   = 9'b0_11_00_0_0_0;
   localparam logic [8:0] M_MA  = 9'b1_10_00_0_0_0;
   localparam logic [8:0] M_MR  = 9'b0_00_00_1_0_0;
   localparam logic [8:0] M_MWB = 9'b0_00_00_0_0_1;
   localparam logic [8:0] M_MW  = 9'b0_00_00_1_0_0;
   localparam logic [8:0] M_EX  = 9'b1_00_00_0_0_0;
   localparam logic [8:0] M_AWB = 9'b0_00_00_0_1_0;
   localparam logic [8:0] M_BR  = 9'b1_00_01_0_0_0;
   localparam logic [8:0] M_IEX = 9'b1_10_00_0_0_0;
   localparam logic [8:0] M_IWB = 9'b0_00_00_0_0_0;
   localparam logic [8:0] M_J   = 9'b0_00_10_0_0_0;

   vec_t vq[$];
   int   total = 0;
   int   bad   = 0;
   logic cur_ill = 1'b0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [3:0] st, input logic [3:0] alu, input logic [3:0] en,
                      input logic [8:0] mux, input logic imm);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.st = st; v.alu = alu;
      v.en = en; v.mux = mux; v.imm = imm; v.ill = cur_ill;
      vq.push_back(v);
   endtask

   task automatic fd(input logic [5:0] op, input logic [5:0] fn, input logic z);
      add(op, fn, z, 4'd0, 4'b0010, 4'b1100, M_F, 1'b0);
      add(op, fn, z, 4'd1, 4'b0010, 4'b0000, M_D, 1'b0);
   endtask

   task automatic r_seq(input logic [5:0] fn, input logic [3:0] alu);
      fd(6'b000000, fn, 1'b0);
      add(6'b000000, fn, 1'b0, 4'd6, alu,     4'b0000, M_EX,  1'b0);
      add(6'b000000, fn, 1'b0, 4'd7, 4'b0010, 4'b0001, M_AWB, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- expectation table ----
      r_seq(6'b100000, 4'b0010);
      r_seq(6'b100010, 4'b0110);
      r_seq(6'b100100, 4'b0000);
      r_seq(6'b100101, 4'b0001);
      r_seq(6'b101010, 4'b0111);
      r_seq(6'b100111, 4'b1100);
      fd(6'b100011, 6'd0, 1'b0);                                   // lw
      add(6'b100011, 6'd0, 1'b0, 4'd2, 4'b0010, 4'b0000, M_MA,  1'b0);
      add(6'b100011, 6'd0, 1'b0, 4'd3, 4'b0010, 4'b0000, M_MR,  1'b0);
      add(6'b100011, 6'd0, 1'b0, 4'd4, 4'b0010, 4'b0001, M_MWB, 1'b0);
      fd(6'b101011, 6'd0, 1'b0);                                   // sw
      add(6'b101011, 6'd0, 1'b0, 4'd2, 4'b0010, 4'b0000, M_MA,  1'b0);
      add(6'b101011, 6'd0, 1'b0, 4'd5, 4'b0010, 4'b0010, M_MW,  1'b0);
      fd(6'b000100, 6'd0, 1'b0);                                   // beq taken
      add(6'b000100, 6'd0, 1'b1, 4'd8, 4'b0110, 4'b1000, M_BR,  1'b0);
      fd(6'b000100, 6'd0, 1'b1);                                   // beq not taken
      add(6'b000100, 6'd0, 1'b0, 4'd8, 4'b0110, 4'b0000, M_BR,  1'b0);
      fd(6'b001000, 6'd0, 1'b0);                                   // addi
      add(6'b001000, 6'd0, 1'b0, 4'd9,  4'b0010, 4'b0000, M_IEX, 1'b0);
      add(6'b001000, 6'd0, 1'b0, 4'd10, 4'b0010, 4'b0001, M_IWB, 1'b0);
      fd(6'b111111, 6'd0, 1'b0);                                   // illegal opcode
      cur_ill = 1'b1;
      fd(6'b000010, 6'd0, 1'b0);                                   // j
      add(6'b000010, 6'd0, 1'b0, 4'd11, 4'b0010, 4'b1000, M_J,  1'b0);
`ifdef MIPS_MC_IMM_LOGIC_EN
      fd(6'b001101, 6'd0, 1'b0);                                   // ori
      add(6'b001101, 6'd0, 1'b0, 4'd12, 4'b0001, 4'b0000, M_IEX, 1'b1);
      add(6'b001101, 6'd0, 1'b0, 4'd10, 4'b0010, 4'b0001, M_IWB, 1'b0);
      fd(6'b001100, 6'd0, 1'b0);                                   // andi
      add(6'b001100, 6'd0, 1'b0, 4'd12, 4'b0000, 4'b0000, M_IEX, 1'b1);
      add(6'b001100, 6'd0, 1'b0, 4'd10, 4'b0010, 4'b0001, M_IWB, 1'b0);
`else
      fd(6'b001101, 6'd0, 1'b0);                                   // ori illegal
      fd(6'b001100, 6'd0, 1'b0);                                   // andi illegal
`endif
      fd(6'b000000, 6'b000001, 1'b0);                              // bad funct
      add(6'b100011, 6'd0, 1'b0, 4'd0, 4'b0010, 4'b1100, M_F, 1'b0); // lw fetch

      // ---- reset for two cycles ----
      rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk("rst_estado", c, 32'(estado), 32'd0);
         chk("rst_illegal", c, 32'(illegal_op), 32'd0);
         chk("rst_pc_en", c, 32'(pc_en), 32'd0);
         chk("rst_ir_write", c, 32'(ir_write), 32'd0);
         chk("rst_alu", c, 32'(alu_control), 32'h2);
      end
      rst_n = 1'b1; #1;
      chk("rel_ir_write", 0, 32'(ir_write), 32'd1);
      chk("rel_pc_en", 0, 32'(pc_en), 32'd1);
      chk("rel_alu", 0, 32'(alu_control), 32'h2);

      // ---- table run: each entry is one cycle ----
      foreach (vq[i]) begin
         opcode = vq[i].op; funct = vq[i].fn; zero = vq[i].z;
         #1;
         chk("estado", i, 32'(estado), 32'(vq[i].st));
         chk("alu_control", i, 32'(alu_control), 32'(vq[i].alu));
         chk("enables", i, 32'({pc_en, ir_write, mem_write, reg_write}), 32'(vq[i].en));
         chk("muxes", i, 32'({alu_src_a, alu_src_b, pc_src, i_or_d, reg_dst, mem_to_reg}), 32'(vq[i].mux));
         chk("illegal_op", i, 32'(illegal_op), 32'(vq[i].ill));
`ifdef MIPS_MC_IMM_LOGIC_EN
         chk("imm_zext", i, 32'(imm_zext), 32'(vq[i].imm));
`endif
         @(posedge clk); #1;
      end

      // ---- reset in the middle of lw writeback ----
      chk("mid_decode", 0, 32'(estado), 32'd1);
      @(posedge clk); #1;
      chk("mid_memadr", 0, 32'(estado), 32'd2);
      @(posedge clk); #1;
      chk("mid_memrd", 0, 32'(estado), 32'd3);
      @(posedge clk); #1;
      chk("mid_memwb", 0, 32'(estado), 32'd4);
      chk("mid_memwb_rw", 0, 32'(reg_write), 32'd1);
      rst_n = 1'b0; #1;
      chk("mid_rst_rw", 0, 32'(reg_write), 32'd0);
      chk("mid_rst_m2r", 0, 32'(mem_to_reg), 32'd0);
      chk("mid_rst_srcb", 0, 32'(alu_src_b), 32'd1);
      chk("mid_rst_ill", 0, 32'(illegal_op), 32'd1);
      chk("mid_rst_en", 0, 32'({pc_en, ir_write, mem_write, reg_write}), 32'd0);
      @(posedge clk); #1;
      chk("mid_after_st", 0, 32'(estado), 32'd0);
      chk("mid_after_ill", 0, 32'(illegal_op), 32'd0);
      chk("mid_after_irw", 0, 32'(ir_write), 32'd0);
      rst_n = 1'b1; #1;
      chk("mid_rel_irw", 0, 32'(ir_write), 32'd1);
      chk("mid_rel_pc_en", 0, 32'(pc_en), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
